// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: shared scan states and width helper for the 7-segment scan controller
package seg7_scan_ctrl_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: datapath/decoder/display-pin bundle of the scan controller
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [3:0]              dig_code;
    logic [6:0]              seg_in;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    pending;
    logic                    frame_tick;

    modport master (
        output load, data_in, seg_in,
        input  dig_code, seg_out, an_n, pending, frame_tick
    );

    modport slave (
        input  load, data_in, seg_in,
        output dig_code, seg_out, an_n, pending, frame_tick
    );
endinterface

// File: rtl/seg7_prescaler.sv
// seg7_prescaler: slot counter, digit index and slot/frame/blank flags
module seg7_prescaler
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int  NUM_DIGITS = 4,
    parameter int  SCAN_DIV   = 1000,
    parameter int  BLANK_CYC  = 16,
    localparam int CW         = cw(SCAN_DIV),
    localparam int IW         = cw(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output logic [IW-1:0] idx,
    output logic          slot_end,
    output logic          frame_end,
    output logic          in_blank
);
    assign slot_end  = cnt == CW'(SCAN_DIV - 1);
    assign frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
    assign in_blank  = cnt < CW'(BLANK_CYC);

    // wrap cnt every slot and step to the next digit on each wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end) idx <= frame_end ? '0 : idx + IW'(1);
        end
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: double-buffered multiplexed 7-segment scan; `define SEG7_LZB_EN enables leading-zero blanking
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 16
) (
    input logic             clk,
    input logic             rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int CW = cw(SCAN_DIV);
    localparam int IW = cw(NUM_DIGITS);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    slot_end, frame_end, in_blank;
    logic [4*NUM_DIGITS-1:0] active, shadow;
    logic                    pending_r;
    logic [6:0]              seg_r;
    logic [NUM_DIGITS-1:0]   lit;
    logic                    show;
    state_t                  state, state_nx;

    seg7_prescaler #(
        .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_presc (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .idx      (idx),
        .slot_end (slot_end),
        .frame_end(frame_end),
        .in_blank (in_blank)
    );

    // shadow captures loads anytime; active only swaps at the frame boundary so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            active    <= '0;
            pending_r <= 1'b0;
        end else begin
            if (bus.load) shadow <= bus.data_in;
            if (frame_end && pending_r) active <= shadow;
            pending_r <= bus.load || (pending_r && !frame_end);
        end
    end

    // slot phase register
    always_ff @(posedge clk) begin
        state <= rst ? ST_BLANK : state_nx;
    end

    // enter SHOW after the last blank cycle, return to BLANK after the slot's last cycle
    always_comb begin
        state_nx = (slot_end || (in_blank && cnt != CW'(BLANK_CYC - 1))) ? ST_BLANK : ST_SHOW;
        show     = !rst && state == ST_SHOW && lit[idx];
    end

    // a digit stays dark when it and every more significant digit are zero; digit 0 always lit
    always_comb begin
        lit = '1;
`ifdef SEG7_LZB_EN
        for (int k = 1; k < NUM_DIGITS; k++) lit[k] = |(active >> (4 * k));
`endif
    end

    // sample the decoder only while showing so the first SHOW cycle drives no stale pattern
    always_ff @(posedge clk) begin
        seg_r <= show ? bus.seg_in : '0;
    end

    assign bus.dig_code   = active[4*idx +: 4];
    assign bus.an_n       = show ? ~(NUM_DIGITS'(1) << idx) : '1;
    assign bus.seg_out    = show ? seg_r : '0;
    assign bus.pending    = pending_r;
    assign bus.frame_tick = frame_end && !rst;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scoreboard bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles)
module tb_seg7_scan_ctrl;
    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FP = ND * SD;

    typedef struct {
        int          frame;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    exp_t q[$];
    logic [15:0] cur = '0;
    int   f, fpos, slot, c;
    logic [3:0] nib;
    logic lt;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign bus.seg_in = dec(bus.dig_code);

    always #5 clk = ~clk;

    always @(posedge clk) if (run) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int at);
        while (cyc < at) step();
    endtask

    task automatic do_load(input logic [15:0] v, input int at, input int fr);
        go_to(at);
        bus.load    = 1'b1;
        bus.data_in = v;
        q.push_back('{fr, v});
        step();
        bus.load = 1'b0;
    endtask

    task automatic check_pend(input int at, input logic exp);
        go_to(at);
        @(negedge clk);
        check($sformatf("pending@%0d", at), 32'(bus.pending), 32'(exp));
    endtask

    // scoreboard monitor: expected display value changes only at the frame pushed with each load
    always @(negedge clk) begin
        if (run) begin
            f    = cyc / FP;
            fpos = cyc % FP;
            slot = fpos / SD;
            c    = fpos % SD;
            while (q.size() > 0 && q[0].frame <= f) begin
                cur = q[0].val;
                void'(q.pop_front());
            end
            nib = 4'((cur >> (4 * slot)) & 16'hF);
`ifdef SEG7_LZB_EN
            lt = slot == 0 || (cur >> (4 * slot)) != 0;
`else
            lt = 1'b1;
`endif
            check($sformatf("dig_code@%0d", cyc), 32'(bus.dig_code), 32'(nib));
            check($sformatf("an_n@%0d", cyc), 32'(bus.an_n),
                  (c < BC || !lt) ? 32'hF : 32'(4'(~(4'b1 << slot))));
            check($sformatf("seg_out@%0d", cyc), 32'(bus.seg_out),
                  (c > BC && lt) ? 32'(dec(nib)) : 32'h0);
            check($sformatf("frame_tick@%0d", cyc), 32'(bus.frame_tick), 32'(fpos == FP - 1));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load    = 1'b0;
        bus.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an_n", 32'(bus.an_n), 32'hF);
        check("rst_seg_out", 32'(bus.seg_out), 32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
        check("rst_dig_code", 32'(bus.dig_code), 32'h0);
        rst = 1'b0;
        run = 1'b1;
        do_load(16'h1234, 0, 1);
        check_pend(5, 1'b1);
        check_pend(31, 1'b1);
        check_pend(32, 1'b0);
        do_load(16'h5678, 42, 2);
        check_pend(50, 1'b1);
        do_load(16'h9999, 63, 3);
        check_pend(64, 1'b1);
        check_pend(95, 1'b1);
        check_pend(96, 1'b0);
        do_load(16'h0007, 100, 4);
        do_load(16'h0000, 140, 5);
        do_load(16'h0100, 170, 6);
        go_to(8 * FP);
        run = 1'b0;
        bus.load    = 1'b1;
        bus.data_in = 16'h4321;
        step();
        bus.load = 1'b0;
        @(negedge clk);
        check("pre_rst_pending", 32'(bus.pending), 32'h1);
        repeat (2 * SD + 2) step();
        @(negedge clk);
        check("pre_rst_dig_code", 32'(bus.dig_code), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_an_n", 32'(bus.an_n), 32'hF);
        check("mid_rst_seg_out", 32'(bus.seg_out), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_pending", 32'(bus.pending), 32'h0);
        check("post_rst_an_n", 32'(bus.an_n), 32'hF);
        repeat (2 * SD + BC + 1) step();
        @(negedge clk);
        check("post_rst_dig_code", 32'(bus.dig_code), 32'h0);
        check("post_rst_frame_tick", 32'(bus.frame_tick), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
